ram_sp_sr_sw: RTL and testbench



---
 rtl/ram_sp_sr_sw_pkg.sv | 18 +
 rtl/ram_sp_sr_sw_if.sv | 20 ++
 rtl/ram_sp_array.sv | 29 ++
 rtl/ram_sp_sr_sw.sv | 49 ++++
 tb/tb_ram_sp_sr_sw.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/ram_sp_sr_sw_pkg.sv
// ram_sp_sr_sw_pkg: default geometry and bus-operation decoding shared by the RAM files.
package ram_sp_sr_sw_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_WRITE,
        OP_READ
    } op_e;

    // Write wins over read so the RAM never drives while an external writer does.
    function automatic op_e decode_op(input logic cs, input logic we, input logic oe);
        return !cs ? OP_IDLE : we ? OP_WRITE : oe ? OP_READ : OP_IDLE;
    endfunction

endpackage

// File: rtl/ram_sp_sr_sw_if.sv
// ram_sp_sr_sw_if: address and control strobes of the RAM bus.
//   address : word address
//   cs/we/oe: chip select, write enable, output enable (all active high)
// The bidirectional data bus stays a plain inout port on the RAM so that
// tri-state resolution happens on an ordinary net.
interface ram_sp_sr_sw_if
    import ram_sp_sr_sw_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] address;
    logic                  cs;
    logic                  we;
    logic                  oe;

    modport master (output address, cs, we, oe);
    modport slave  (input  address, cs, we, oe);

endinterface

// File: rtl/ram_sp_array.sv
// ram_sp_array: DATA_WIDTH x 2^ADDR_WIDTH storage array, written on the rising clock edge.
//   clk   : clock
//   we    : write strobe for this edge
//   addr  : shared read/write address
//   wdata : write data
//   rdata : word at addr, registered by the caller
// The array has no reset; contents are undefined until written.
module ram_sp_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/ram_sp_sr_sw.sv
// ram_sp_sr_sw: single-port RAM, synchronous write and read over a shared tri-state data bus.
//   clk  : clock
//   rst  : asynchronous active-high reset (clears the read register only)
//   bus  : address, cs, we, oe
//   data : bidirectional data bus; sampled on write, driven only during an enabled read
module ram_sp_sr_sw
    import ram_sp_sr_sw_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_sp_sr_sw_if.slave         bus,
    inout  wire  [DATA_WIDTH-1:0] data
);

    op_e                   op;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic [DATA_WIDTH-1:0] rd_d;
    logic [DATA_WIDTH-1:0] rd_q;

    always_comb begin
        op    = decode_op(bus.cs, bus.we, bus.oe);
        wr_en = op == OP_WRITE;
        rd_d  = (op == OP_READ) ? arr_rdata : rd_q;
    end

    ram_sp_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (wr_en),
        .addr (bus.address),
        .wdata(data),
        .rdata(arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_q <= '0;
        else     rd_q <= rd_d;
    end

    // Drive enable is combinational so the bus shows the held word (stale) until the read edge.
    assign data = (op == OP_READ) ? rd_q : 'z;

endmodule

// File: tb/tb_ram_sp_sr_sw.sv
// tb_ram_sp_sr_sw: vector table, corner sequences and random traffic against a memory model.
module tb_ram_sp_sr_sw;

    localparam int DW = 8;
    localparam int AW = 8;

    typedef struct {
        logic          cs;
        logic          we;
        logic          oe;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // When the RAM must not drive, the bench drives wdata (0 as an idle probe);
    // any RAM drive at the same time corrupts the observed value.
    logic          tb_en  = 1'b1;
    logic [DW-1:0] tb_val = '0;
    wire  [DW-1:0] data;
    assign data = tb_en ? tb_val : 'z;

    ram_sp_sr_sw_if #(.ADDR_WIDTH(AW)) bus ();

    ram_sp_sr_sw #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .data(data)
    );

    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] ref_rd = '0;
    int n_chk  = 0;
    int n_fail = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: data=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic w, input logic o, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.cs      = c;
        bus.we      = w;
        bus.oe      = o;
        bus.address = a;
        tb_en       = !(c && !w && o);
        tb_val      = d;
    endtask

    function automatic logic [DW-1:0] exp_bus(input logic c, input logic w, input logic o, input logic [DW-1:0] d);
        return (c && !w && o) ? ref_rd : d;
    endfunction

    // One bus cycle: drive at negedge, update the model at the edge, leave time at edge+1.
    task automatic cycle(input logic c, input logic w, input logic o, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        drive(c, w, o, a, d);
        @(posedge clk);
        if (c && w) ref_mem[a] = d;
        else if (c && o) ref_rd = ref_mem[a];
        #1;
    endtask

    initial begin
        vecs = '{
            '{1, 1, 0, 8'h10, 8'hAA, 8'hAA},
            '{1, 0, 1, 8'h10, 8'h00, 8'hAA},
            '{1, 1, 0, 8'h20, 8'h55, 8'h55},
            '{1, 0, 1, 8'h20, 8'h00, 8'h55},
            '{1, 0, 1, 8'h10, 8'h00, 8'hAA},
            '{1, 1, 1, 8'h05, 8'h3C, 8'h3C},
            '{1, 0, 1, 8'h05, 8'h00, 8'h3C},
            '{0, 1, 0, 8'h10, 8'hFF, 8'hFF},
            '{1, 0, 0, 8'h10, 8'h00, 8'h00},
            '{0, 0, 1, 8'h10, 8'h00, 8'h00},
            '{1, 0, 1, 8'h10, 8'h00, 8'hAA},
            '{1, 1, 0, 8'h00, 8'h01, 8'h01},
            '{1, 0, 1, 8'h00, 8'h00, 8'h01},
            '{1, 1, 0, 8'hFF, 8'h80, 8'h80},
            '{1, 0, 1, 8'hFF, 8'h00, 8'h80}
        };

        drive(0, 0, 0, '0, '0);
        #12;
        check("reset_bus_z", data, 8'h00);
        rst = 1'b0;
        drive(1, 0, 1, 8'h00, '0);
        #1;
        check("reset_rd_zero", data, 8'h00);

        foreach (vecs[i]) begin
            cycle(vecs[i].cs, vecs[i].we, vecs[i].oe, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d", i), data, vecs[i].exp);
        end

        // Before the read edge the bus still shows the previously read word.
        @(negedge clk);
        drive(1, 0, 1, 8'h10, '0);
        #1;
        check("stale_before_edge", data, 8'h80);
        @(posedge clk);
        ref_rd = ref_mem[8'h10];
        #1;
        check("read_after_stale", data, 8'hAA);

        // Asynchronous reset in the middle of a read cycle.
        cycle(1, 0, 1, 8'hFF, '0);
        check("read_ff", data, 8'h80);
        #2;
        rst = 1'b1;
        ref_rd = '0;
        #1;
        check("reset_mid_read", data, 8'h00);
        rst = 1'b0;
        cycle(1, 0, 1, 8'hFF, '0);
        check("mem_kept_after_reset", data, 8'h80);

        for (int a = 0; a < (1 << AW); a++) begin
            logic [DW-1:0] d;
            logic          o;
            d = DW'($urandom);
            o = 1'($urandom);
            cycle(1, 1, o, AW'(a), d);
            check("fill", data, exp_bus(1, 1, o, d));
        end

        for (int i = 0; i < 400; i++) begin
            logic          c, w, o;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int            k;
            k = $urandom_range(0, 4);
            a = AW'($urandom);
            d = DW'($urandom);
            c = k != 3;
            w = k == 0;
            o = k == 4 ? 1'b0 : 1'($urandom) | (k != 0);
            if (!(c && w)) d = (k == 3) ? d : '0;
            cycle(c, w, o, a, d);
            check($sformatf("rand%0d", i), data, exp_bus(c, w, o, d));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
